// File: rtl/out_intf_arb_pkg.sv
// rtl/out_intf_arb_pkg.sv - shared types and default sizes for the out_intf packet arbiter
package out_intf_arb_pkg;

  localparam int OUT_INTF_NUM_REQ    = 4;
  localparam int OUT_INTF_DATA_WIDTH = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [OUT_INTF_DATA_WIDTH-1:0] data;
    logic                           last;
  } out_beat_t;

endpackage

// File: rtl/out_intf_rr_picker.sv
// rtl/out_intf_rr_picker.sv - combinational round-robin winner search starting after last_grant
module out_intf_rr_picker
  import out_intf_arb_pkg::*;
#(
  parameter int NUM_REQ  = OUT_INTF_NUM_REQ,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] last_grant_i,
  output logic [ID_WIDTH-1:0] winner_o,
  output logic                any_req_o
);

  logic [NUM_REQ-1:0]  rot;
  logic [ID_WIDTH-1:0] offset;

  // Rotate so the slot after last_grant sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot    = '0;
    offset = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rot[k] = req_i[ID_WIDTH'((int'(last_grant_i) + 1 + k) % NUM_REQ)];
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) offset = ID_WIDTH'(k);
    end
    winner_o  = ID_WIDTH'((int'(last_grant_i) + 1 + int'(offset)) % NUM_REQ);
    any_req_o = |req_i;
  end

endmodule

// File: rtl/out_intf_arb.sv
// rtl/out_intf_arb.sv - packet-locked round-robin arbiter driving the out_intf output register
module out_intf_arb
  import out_intf_arb_pkg::*;
#(
  parameter int NUM_REQ    = OUT_INTF_NUM_REQ,
  parameter int DATA_WIDTH = OUT_INTF_DATA_WIDTH,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          out_valid_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic                          out_last_o,
  input  logic                          out_ready_i,
  output logic [ID_WIDTH-1:0]           grant_id_o,
  output logic                          busy_o,
  output logic [15:0]                   pkt_count_o
);

  arb_state_t          state_q;
  logic [ID_WIDTH-1:0] grant_q;
  logic [ID_WIDTH-1:0] last_grant_q;
  logic [15:0]         pkt_count_q;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;

  logic [ID_WIDTH-1:0]   winner;
  logic                  any_req;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  slot_free;
  logic                  accept;

  out_intf_rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req_i        (req_valid_i),
    .last_grant_i (last_grant_q),
    .winner_o     (winner),
    .any_req_o    (any_req)
  );

  // Pull the grantee's beat out of the flattened request bus.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_valid = req_valid_i[i];
        sel_last  = req_last_i[i];
        sel_data  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign slot_free = !out_valid_q || out_ready_i;
  assign accept    = (state_q == LOCKED) && sel_valid && slot_free;

  // Only the grantee sees ready, and only when the output slot can take a beat.
  always_comb begin
    req_ready_o = '0;
    if (state_q == LOCKED) req_ready_o[grant_q] = slot_free;
  end

  // A loaded beat overwrites the slot (no bubble); otherwise a downstream accept empties it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = sel_last;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Arbitration FSM: lock onto a winner in IDLE, release on the accepted last beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      pkt_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= winner;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && sel_last) begin
            state_q      <= IDLE;
            last_grant_q <= grant_q;
            pkt_count_q  <= pkt_count_q + 16'd1;
          end
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign grant_id_o  = grant_q;
  assign busy_o      = (state_q == LOCKED);
  assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_out_intf_arb.sv
// tb/tb_out_intf_arb.sv - self-checking bench for the out_intf packet arbiter
module tb_out_intf_arb;

  localparam int NP = 6;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_last;
  logic [31:0]  dval [4];
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_last;
  logic         out_ready;
  logic [1:0]   grant_id;
  logic         busy;
  logic [15:0]  pkt_count;

  int n_chk;
  int n_fail;

  assign req_data = {dval[3], dval[2], dval[1], dval[0]};

  out_intf_arb dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_ready_i (out_ready),
    .grant_id_o  (grant_id),
    .busy_o      (busy),
    .pkt_count_o (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    logic [1:0] exp_grant;
  } vec_t;

  vec_t vecs [10];

  int pk [4];
  int bt [4];
  int nxt_out [4];
  int lens [4][NP];
  int exp_q [$];
  int cur_own, cur_beat, model_last;
  int r_o, p_o, b_o, er, w, cyc;
  bit done, stall_prev;
  logic [31:0] stall_data;
  logic [3:0] acc;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mkd(int r, int p, int b);
    return {8'h5A, r[7:0], p[7:0], b[7:0]};
  endfunction

  function automatic int rr(int last, logic [3:0] m);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (m[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic one_beat(int r, logic [31:0] d);
    req_valid = '0;
    req_last  = '0;
    req_valid[r[1:0]] = 1'b1;
    req_last[r[1:0]]  = 1'b1;
    dval[r[1:0]] = d;
    nxt();
    nxt();
    req_valid = '0;
    req_last  = '0;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    vecs[0] = '{4'b1111, 2'd0};
    vecs[1] = '{4'b1111, 2'd1};
    vecs[2] = '{4'b0101, 2'd2};
    vecs[3] = '{4'b0011, 2'd0};
    vecs[4] = '{4'b1000, 2'd3};
    vecs[5] = '{4'b1001, 2'd0};
    vecs[6] = '{4'b0110, 2'd1};
    vecs[7] = '{4'b0010, 2'd1};
    vecs[8] = '{4'b1100, 2'd2};
    vecs[9] = '{4'b0001, 2'd0};

    rst_n = 1'b0;
    req_valid = '0;
    req_last = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) dval[i] = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table: one-beat packets from a set of requesters; grant follows round-robin order.
    for (int v = 0; v < 10; v++) begin
      req_valid = vecs[v].mask;
      req_last  = 4'hF;
      for (int i = 0; i < 4; i++) dval[i] = 32'hC000_0000 | 32'(v << 8) | 32'(i);
      nxt();
      chk("tbl_grant", 32'(grant_id), 32'(vecs[v].exp_grant));
      chk("tbl_busy", 32'(busy), 32'd1);
      nxt();
      req_valid = '0;
      @(negedge clk);
      chk("tbl_out_valid", 32'(out_valid), 32'd1);
      chk("tbl_out_data", out_data, 32'hC000_0000 | 32'(v << 8) | 32'(vecs[v].exp_grant));
      chk("tbl_out_last", 32'(out_last), 32'd1);
      chk("tbl_idle_after_last", 32'(busy), 32'd0);
      nxt();
    end
    chk("tbl_pkt_count", 32'(pkt_count), 32'd10);

    // Single 3-beat packet from requester 2.
    req_valid = 4'b0100;
    req_last = '0;
    dval[2] = 32'hA0;
    @(negedge clk);
    chk("sp_c0_busy", 32'(busy), 32'd0);
    chk("sp_c0_ready", 32'(req_ready), 32'd0);
    nxt();
    @(negedge clk);
    chk("sp_c1_grant", 32'(grant_id), 32'd2);
    chk("sp_c1_ready", 32'(req_ready), 32'b0100);
    chk("sp_c1_out_valid", 32'(out_valid), 32'd0);
    nxt();
    dval[2] = 32'hA1;
    @(negedge clk);
    chk("sp_c2_valid", 32'(out_valid), 32'd1);
    chk("sp_c2_data", out_data, 32'hA0);
    chk("sp_c2_last", 32'(out_last), 32'd0);
    nxt();
    dval[2] = 32'hA2;
    req_last[2] = 1'b1;
    @(negedge clk);
    chk("sp_c3_data", out_data, 32'hA1);
    nxt();
    req_valid = '0;
    req_last = '0;
    @(negedge clk);
    chk("sp_c4_data", out_data, 32'hA2);
    chk("sp_c4_last", 32'(out_last), 32'd1);
    chk("sp_c4_busy", 32'(busy), 32'd0);
    chk("sp_c4_pkt_count", 32'(pkt_count), 32'd11);
    nxt();
    @(negedge clk);
    chk("sp_c5_out_valid", 32'(out_valid), 32'd0);
    nxt();

    // Backpressure: 5 stalled cycles after the first beat of a 4-beat packet.
    req_valid = 4'b0010;
    dval[1] = 32'hB0;
    nxt();
    @(negedge clk);
    chk("bp_grant", 32'(grant_id), 32'd1);
    nxt();
    dval[1] = 32'hB1;
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", out_data, 32'hB0);
      chk("bp_stall_ready", 32'(req_ready), 32'd0);
      nxt();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_ready", 32'(req_ready), 32'b0010);
    nxt();
    dval[1] = 32'hB2;
    @(negedge clk);
    chk("bp_data_b1", out_data, 32'hB1);
    nxt();
    dval[1] = 32'hB3;
    req_last[1] = 1'b1;
    @(negedge clk);
    chk("bp_data_b2", out_data, 32'hB2);
    nxt();
    req_valid = '0;
    req_last = '0;
    @(negedge clk);
    chk("bp_data_b3", out_data, 32'hB3);
    chk("bp_last_b3", 32'(out_last), 32'd1);
    chk("bp_pkt_count", 32'(pkt_count), 32'd12);
    nxt();

    // Lock: requester 1 pauses mid-packet while requester 3 waits.
    req_valid = 4'b0010;
    dval[1] = 32'hC0;
    nxt();
    req_valid[3] = 1'b1;
    req_last[3] = 1'b1;
    dval[3] = 32'hD0;
    @(negedge clk);
    chk("lk_grant", 32'(grant_id), 32'd1);
    nxt();
    req_valid[1] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("lk_hold_grant", 32'(grant_id), 32'd1);
      chk("lk_hold_busy", 32'(busy), 32'd1);
      chk("lk_r3_ready", 32'(req_ready[3]), 32'd0);
      nxt();
    end
    req_valid[1] = 1'b1;
    dval[1] = 32'hC1;
    nxt();
    dval[1] = 32'hC2;
    req_last[1] = 1'b1;
    @(negedge clk);
    chk("lk_data_c1", out_data, 32'hC1);
    nxt();
    req_valid[1] = 1'b0;
    req_last[1] = 1'b0;
    @(negedge clk);
    chk("lk_data_c2", out_data, 32'hC2);
    chk("lk_idle", 32'(busy), 32'd0);
    nxt();
    @(negedge clk);
    chk("lk_grant_r3", 32'(grant_id), 32'd3);
    chk("lk_ready_r3", 32'(req_ready), 32'b1000);
    nxt();
    req_valid = '0;
    req_last = '0;
    @(negedge clk);
    chk("lk_data_d0", out_data, 32'hD0);
    chk("lk_pkt_count", 32'(pkt_count), 32'd14);
    nxt();

    // Reset in the middle of a 4-beat packet.
    one_beat(1, 32'h1111_0001);
    req_valid = 4'b0100;
    dval[2] = 32'hE0;
    nxt();
    nxt();
    dval[2] = 32'hE1;
    nxt();
    dval[2] = 32'hE2;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_out_data", out_data, 32'd0);
    chk("mr_out_last", 32'(out_last), 32'd0);
    chk("mr_req_ready", 32'(req_ready), 32'd0);
    chk("mr_grant", 32'(grant_id), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_pkt_count", 32'(pkt_count), 32'd0);
    req_valid = 4'hF;
    req_last = 4'hF;
    for (int i = 0; i < 4; i++) dval[i] = 32'hF000_0000 | 32'(i);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nxt();
    chk("mr_first_grant", 32'(grant_id), 32'd0);
    nxt();
    req_valid = '0;
    req_last = '0;
    @(negedge clk);
    chk("mr_first_data", out_data, 32'hF000_0000);
    chk("mr_pkt_after", 32'(pkt_count), 32'd1);
    nxt();

    // Counter wrap, starting two packets short of the top.
    @(negedge clk);
    dut.pkt_count_q = 16'hFFFE;
    nxt();
    one_beat(1, 32'h2222_0001);
    @(negedge clk);
    chk("wrap_ffff", 32'(pkt_count), 32'h0000_FFFF);
    nxt();
    one_beat(2, 32'h2222_0002);
    @(negedge clk);
    chk("wrap_zero", 32'(pkt_count), 32'd0);
    nxt();
    nxt();

    // Randomized traffic against a packet-level round-robin model.
    for (int r = 0; r < 4; r++) begin
      pk[r] = 0;
      bt[r] = 0;
      nxt_out[r] = 0;
      for (int p = 0; p < NP; p++) lens[r][p] = $urandom_range(1, 4);
    end
    cur_own = -1;
    cur_beat = 0;
    model_last = 2;
    done = 1'b0;
    stall_prev = 1'b0;
    stall_data = '0;
    cyc = 0;
    while (!done && cyc < 4000) begin
      for (int r = 0; r < 4; r++) begin
        if (pk[r] < NP) begin
          req_valid[r] = ($urandom_range(0, 3) != 0);
          dval[r] = mkd(r, pk[r], bt[r]);
          req_last[r] = (bt[r] == lens[r][pk[r]] - 1);
        end else begin
          req_valid[r] = 1'b0;
          req_last[r] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (stall_prev) begin
        chk("rnd_hold_valid", 32'(out_valid), 32'd1);
        chk("rnd_hold_data", out_data, stall_data);
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (!busy && req_valid != 4'd0) begin
        w = rr(model_last, req_valid);
        exp_q.push_back(w);
        model_last = w;
      end
      chk("rnd_ready_onehot", 32'($onehot0(req_ready)), 32'd1);
      if (!busy) chk("rnd_ready_idle", 32'(req_ready), 32'd0);
      if (out_valid && out_ready) begin
        r_o = int'(out_data[23:16]);
        p_o = int'(out_data[15:8]);
        b_o = int'(out_data[7:0]);
        if (r_o > 3 || p_o >= NP) begin
          chk("rnd_beat_tag", 32'(r_o < 4 && p_o < NP), 32'd1);
        end else begin
          if (cur_own < 0) begin
            if (exp_q.size() > 0) begin
              er = exp_q.pop_front();
              chk("rnd_rr_winner", 32'(r_o), 32'(er));
            end else begin
              chk("rnd_rr_pending", 32'(exp_q.size()), 32'd1);
            end
            chk("rnd_first_beat", 32'(b_o), 32'd0);
            chk("rnd_pkt_order", 32'(p_o), 32'(nxt_out[r_o]));
            cur_own = r_o;
          end else begin
            chk("rnd_beat_owner", 32'(r_o), 32'(cur_own));
            chk("rnd_beat_index", 32'(b_o), 32'(cur_beat + 1));
          end
          cur_beat = b_o;
          chk("rnd_beat_last", 32'(out_last), 32'(b_o == lens[r_o][p_o] - 1));
          if (out_last) begin
            cur_own = -1;
            nxt_out[r_o] = p_o + 1;
          end
        end
      end
      for (int r = 0; r < 4; r++) acc[r] = req_valid[r] && req_ready[r];
      done = 1'b1;
      for (int r = 0; r < 4; r++) if (nxt_out[r] != NP) done = 1'b0;
      nxt();
      for (int r = 0; r < 4; r++) begin
        if (acc[r]) begin
          if (bt[r] == lens[r][pk[r]] - 1) begin
            pk[r]++;
            bt[r] = 0;
          end else begin
            bt[r]++;
          end
        end
      end
      cyc++;
    end
    req_valid = '0;
    req_last = '0;
    out_ready = 1'b1;
    chk("rnd_complete", 32'(done), 32'd1);
    chk("rnd_rr_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("rnd_pkt_count", 32'(pkt_count), 32'(4 * NP));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/out_intf_arb.md
# out_intf_arb

Round-robin packet arbiter that shares the single out_intf output port among NUM_REQ upstream requesters. Grants are locked for a whole packet, from the first beat through the beat flagged last. Accepted beats are forwarded through one registered output stage with valid/ready flow control. Sits directly in front of the out_intf driver/monitor boundary and is the only agent that drives the out_intf data signals.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, beat data width
- ID_WIDTH, $clog2(NUM_REQ), width of grant_id
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester beat data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  per-requester end-of-packet flag
- req_ready  out  NUM_REQ  per-requester beat accept
- out_valid  out  1  output beat valid
- out_data  out  DATA_WIDTH  output beat data
- out_last  out  1  output end-of-packet flag
- out_ready  in  1  downstream accept
- grant_id  out  ID_WIDTH  current or most recent grantee
- busy  out  1  high while state is LOCKED
- pkt_count  out  16  number of completed packets; wraps

## Operation
- The FSM has two states: IDLE and LOCKED. Reset state is IDLE.
- IDLE: if any req_valid is high, pick a winner. The search starts at (last_grant+1) mod NUM_REQ and proceeds upward with wrap. On the next edge, grant_id takes the winner and the state becomes LOCKED. If no req_valid is high, stay in IDLE.
- LOCKED:
  - req_ready[grant_id] = !out_valid || out_ready. All other req_ready bits are 0.
  - A beat is accepted when req_valid[grant_id] && req_ready[grant_id]. On acceptance, the beat's data and last are loaded into the output register and out_valid is set.
  - An accepted beat with last=1 moves the FSM to IDLE, sets last_grant = grant_id, and increments pkt_count.
- Output register:
  - out_valid clears on out_ready when no new beat is loaded in the same cycle.
  - out_data and out_last hold their values while out_valid=1 && out_ready=0.
- A requester that deasserts req_valid mid-packet keeps the grant. No timeout applies.
- req_valid on non-granted requesters is ignored while LOCKED.
- Simultaneous events:
  - A beat is loaded while the output drains (out_ready=1) → the new beat replaces the old one with no bubble.
  - A last beat is accepted while other requesters are waiting → arbitration occurs in the following IDLE cycle.
- pkt_count wraps 0xFFFF → 0x0000.
- Reset mid-packet: all state clears immediately; the partial packet is dropped. Upstream and downstream must be reset together.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_last=0
  - req_ready=0
  - grant_id=0, busy=0, pkt_count=0
  - last_grant=NUM_REQ-1, so the first grant goes to requester 0 when requesters tie.
- req_ready is combinational from state, out_valid and out_ready. All other outputs are registered.
- Latency from a new request to out_valid:
  - cycle 0: request seen in IDLE
  - cycle 1: LOCKED, first beat accepted
  - cycle 2: out_valid high
- Throughput: one beat per cycle within a packet while out_ready=1.
- Between packets there is exactly one IDLE arbitration cycle. Peak throughput for a packet of L beats is L/(L+1).

## Structure
- The package typedefs file holds:
  - arb_state_t enum (IDLE, LOCKED)
  - parameters OUT_INTF_NUM_REQ and OUT_INTF_DATA_WIDTH
  - typedef out_beat_t, a packed struct of data and last
- Sub-module out_intf_rr_picker is purely combinational.
  - Inputs: req vector, last_grant.
  - Outputs: winner index and any_req.
  - Implemented as a rotate, priority-encode, un-rotate.
- The top level holds the FSM, the output register and pkt_count.

## Test plan
- Single packet: req_valid[2]=1 with 3 beats 0xA0,0xA1,0xA2 (last on 0xA2), out_ready=1 → grant_id=2 at cycle 1; out_data 0xA0..0xA2 on cycles 2–4 with out_last on 0xA2; pkt_count=1; busy low from cycle 4.
- Fairness: all 4 requesters hold 1-beat packets continuously → grant order 0,1,2,3,0,…; each out beat is followed by one idle cycle.
- Backpressure: out_ready=0 for 5 cycles mid-packet → out_data stable, req_ready[grant]=0 after the first beat is loaded, no beat lost or duplicated; data resumes in order when out_ready returns.
- Lock: requester 1 mid-packet drops req_valid for 3 cycles while requester 3 asserts req_valid → grant stays 1 and req_ready[3]=0 until requester 1's last beat.
- Reset mid-packet: assert reset during beat 2 of 4 → all outputs reach reset values asynchronously; after release, requester 0 is granted first.
- Wrap: preload via 65536 one-beat packets → pkt_count reads 0x0000.
